toast_imem: RTL and testbench

// - Instruction-memory responder for the fetch stage. Takes the registered byte fetch address and

---
 rtl/toast_imem.sv | 123 ++++++++++++
 tb/tb_toast_imem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/toast_imem.sv
// Instruction memory with a valid/ready boot loader. The core is held while the image streams in.
// Define TOAST_IMEM_PARITY_EN to store an even-parity bit per word and check it on fetch.
module toast_imem #(
  parameter int    REG_DATA_WIDTH  = 32,
  parameter int    IMEM_ADDR_WIDTH = 32,
  parameter int    IMEM_DEPTH      = 1024,
  parameter bit    BOOT_LOAD       = 1'b1,
  parameter string INIT_FILE       = ""
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic [IMEM_ADDR_WIDTH-1:0] IMEM_addr_i,
  output logic [REG_DATA_WIDTH-1:0]  IMEM_data_o,
  input  logic                       load_start_i,
  input  logic                       load_valid_i,
  output logic                       load_ready_o,
  input  logic [REG_DATA_WIDTH-1:0]  load_data_i,
  input  logic                       load_last_i,
  output logic                       core_hold_o,
  output logic                       load_done_o,
  output logic                       load_err_o
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [REG_DATA_WIDTH-1:0] NOP = REG_DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_RUN} state_t;
  localparam state_t RST_STATE = BOOT_LOAD ? S_WAIT : S_RUN;

  state_t                    r_state, w_state_nxt;
  logic [AW-1:0]             r_wr_ptr, w_wr_ptr_nxt;
  logic [REG_DATA_WIDTH-1:0] r_data;
  logic                      r_done, r_err;
  logic                      w_wr_en, w_fin, w_ovf;
  logic [AW-1:0]             w_rd_idx;
  logic                      w_oob, w_par_err;
  logic [REG_DATA_WIDTH-1:0] w_rd_word;

  logic [REG_DATA_WIDTH-1:0] r_mem [IMEM_DEPTH];
`ifdef TOAST_IMEM_PARITY_EN
  logic                      r_par [IMEM_DEPTH];
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= RST_STATE;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
    end
  end

  // ready is only ever high in LOAD, so a valid beat there is always accepted
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_en      = 1'b0;
    w_fin        = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (load_start_i) begin
          w_state_nxt  = S_LOAD;
          w_wr_ptr_nxt = '0;
        end
      end
      S_LOAD: begin
        if (load_valid_i) begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + AW'(1);
          if (load_last_i) begin
            w_fin = 1'b1;
          end else if (r_wr_ptr == AW'(IMEM_DEPTH - 1)) begin
            w_fin = 1'b1;
            w_ovf = 1'b1;
          end
          if (w_fin) w_state_nxt = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= load_data_i;
`ifdef TOAST_IMEM_PARITY_EN
      r_par[r_wr_ptr] <= ^load_data_i;
`endif
    end
  end

  // Addresses past the array return NOP rather than aliasing onto low words
  assign w_rd_idx  = IMEM_addr_i[2 +: AW];
  assign w_oob     = |(IMEM_addr_i >> (AW + 2));
  assign w_rd_word = r_mem[w_rd_idx];

`ifdef TOAST_IMEM_PARITY_EN
  assign w_par_err = (r_state == S_RUN) && !w_oob && (^{w_rd_word, r_par[w_rd_idx]});
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_data <= NOP;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_ovf || w_par_err) r_err <= 1'b1;
      if (r_state == S_RUN && !w_oob && !w_par_err) r_data <= w_rd_word;
      else                                           r_data <= NOP;
    end
  end

  assign IMEM_data_o  = r_data;
  assign load_ready_o = (r_state == S_LOAD);
  assign core_hold_o  = (r_state != S_RUN);
  assign load_done_o  = r_done;
  assign load_err_o   = r_err;

endmodule

// File: tb/tb_toast_imem.sv
// Randomized bench for toast_imem: image loads against a word-array model, plus overflow on a 4-word part.
module tb_toast_imem;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr = '0, ldata = '0, dout;
  logic        lstart = 1'b0, lvalid = 1'b0, llast = 1'b0;
  logic        lready, hold, done, err;

  logic [31:0] s_addr = '0, s_ldata = '0, s_dout;
  logic        s_start = 1'b0, s_valid = 1'b0;
  logic        s_ready, s_hold, s_done, s_err;

  toast_imem #(.IMEM_DEPTH(1024), .BOOT_LOAD(1'b1)) dut (
    .clk_i(clk), .resetn_i(rst_n), .IMEM_addr_i(addr), .IMEM_data_o(dout),
    .load_start_i(lstart), .load_valid_i(lvalid), .load_ready_o(lready),
    .load_data_i(ldata), .load_last_i(llast), .core_hold_o(hold),
    .load_done_o(done), .load_err_o(err)
  );

  toast_imem #(.IMEM_DEPTH(4), .BOOT_LOAD(1'b1)) u_small (
    .clk_i(clk), .resetn_i(rst_n), .IMEM_addr_i(s_addr), .IMEM_data_o(s_dout),
    .load_start_i(s_start), .load_valid_i(s_valid), .load_ready_o(s_ready),
    .load_data_i(s_ldata), .load_last_i(1'b0), .core_hold_o(s_hold),
    .load_done_o(s_done), .load_err_o(s_err)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] img [1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (a >= 32'h1000) return NOP;
    return img[a[11:2]];
  endfunction

  // Stream img[0..n-1]; toggle=1 offers a beat every other cycle, else random gaps
  task automatic load_stream(input int n, input bit toggle);
    int  i   = 0;
    int  cyc = 0;
    bit  acc, fin;
    while (i < n && cyc < 5000) begin
      lvalid = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      ldata  = lvalid ? img[i] : $urandom;
      llast  = lvalid ? (i == n - 1) : 1'($urandom_range(0, 1));
      chk("ld_ready", {31'b0, lready}, 32'd1);
      acc = lvalid;
      fin = acc && (i == n - 1);
      tick();
      cyc++;
      if (acc) i++;
      chk("ld_done", {31'b0, done}, {31'b0, fin});
      chk("ld_hold", {31'b0, hold}, {31'b0, !fin});
      chk("ld_nop",  dout, NOP);
    end
    lvalid = 1'b0;
    llast  = 1'b0;
    chk("ld_complete", i, n);
  endtask

  // Random fetches over the first nw words plus out-of-range addresses
  task automatic run_reads(input int n, input int nw);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a + 32'h1000;
      end else begin
        a = ($urandom_range(0, nw - 1) << 2) | $urandom_range(0, 3);
      end
      addr   = a;
      lstart = 1'($urandom_range(0, 1));
      lvalid = 1'($urandom_range(0, 1));
      llast  = 1'($urandom_range(0, 1));
      ldata  = $urandom;
      chk("run_ready", {31'b0, lready}, 32'd0);
      tick();
      chk("rd", dout, ref_rd(a));
      chk("run_hold", {31'b0, hold}, 32'd0);
    end
    lstart = 1'b0;
    lvalid = 1'b0;
    llast  = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data",  dout, NOP);
    chk("rst_hold",  {31'b0, hold},   32'd1);
    chk("rst_ready", {31'b0, lready}, 32'd0);
    chk("rst_done",  {31'b0, done},   32'd0);
    chk("rst_err",   {31'b0, err},    32'd0);
    chk("s_rst_hold", {31'b0, s_hold}, 32'd1);
    chk("s_rst_err",  {31'b0, s_err},  32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("wait_hold",  {31'b0, hold},   32'd1);
    chk("wait_ready", {31'b0, lready}, 32'd0);

    // Overflow on the 4-word instance: the 5th beat must be refused
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ldata = 32'hA000_0000 + 32'(i);
      s_valid = 1'b1;
      chk("s_ready", {31'b0, s_ready}, {31'b0, (i < 4)});
      tick();
      chk("s_done", {31'b0, s_done}, {31'b0, (i == 3)});
      chk("s_err",  {31'b0, s_err},  {31'b0, (i >= 3)});
      chk("s_hold", {31'b0, s_hold}, {31'b0, (i < 3)});
    end
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_addr = (i == 5) ? 32'h0000_0400 : (32'(i) << 2) | 32'($urandom_range(0, 3));
      tick();
      chk("s_rd", s_dout, (i < 4) ? 32'hA000_0000 + 32'(i) : NOP);
    end

    // Reset in the middle of a load
    lstart = 1'b1;
    tick();
    lstart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lvalid = 1'b1;
      ldata  = $urandom;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_data",  dout, NOP);
    chk("abort_hold",  {31'b0, hold},   32'd1);
    chk("abort_err",   {31'b0, err},    32'd0);
    chk("abort_ready", {31'b0, lready}, 32'd0);
    lvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_wait", {31'b0, lready}, 32'd0);

    // Directed three-word boot image with a beat every other cycle
    img[0] = 32'h0050_0093;
    img[1] = 32'h0010_8113;
    img[2] = 32'h0000_0013;
    lstart = 1'b1;
    tick();
    lstart = 1'b0;
    load_stream(3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i) << 2;
      tick();
      chk("dir_rd", dout, img[i]);
      if (i == 0) chk("done_pulse", {31'b0, done}, 32'd0);
    end
    chk("dir_err", {31'b0, err}, 32'd0);
    run_reads(40, 3);

    // Reset out of RUN clears the output register without waiting for a clock
    addr = 32'h4;
    tick();
    chk("pre_rst_rd", dout, img[1]);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", dout, NOP);
    chk("async_hold", {31'b0, hold}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Random image with random gaps
    for (int i = 0; i < 200; i++) img[i] = $urandom;
    lstart = 1'b1;
    tick();
    lstart = 1'b0;
    load_stream(200, 1'b0);
    run_reads(150, 200);
    chk("rand_err", {31'b0, err}, 32'd0);

`ifdef TOAST_IMEM_PARITY_EN
    dut.r_mem[1] = dut.r_mem[1] ^ 32'h0000_0100;
    addr = 32'h4;
    tick();
    chk("par_data", dout, NOP);
    chk("par_err",  {31'b0, err}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
